quad_decoder: RTL and testbench

Quadrature encoder decoder. Takes the raw A/B phase inputs from an incremental encoder and maintains a signed-agnostic position count that steps up or down one per valid Gray-code transition. It is the input-side counterpart of the team's up/down counter: direction and step are recovered from the A/B phases instead of being supplied as a mode pin. It sits between the encoder I/O pads and any logic consuming position, direction or step events.

---
 rtl/qdec_pkg.sv | 38 +++
 rtl/qdec_sync_filter.sv | 69 ++++++
 rtl/quad_decoder.sv | 176 +++++++++++++++++
 tb/tb_quad_decoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qdec_pkg.sv
// ---------------------------------------------------------------------------
// qdec_pkg
// Shared definitions for the quadrature decoder:
//   - qdec_state_e : decoder FSM states (PRIME while the input pipeline
//                    fills, TRACK while decoding)
//   - FWD_NEXT_xx  : forward (up) successor of each Gray state {A,B}
//   - DEF_*        : default parameter values
//   - fwd_next()   : forward successor lookup
// ---------------------------------------------------------------------------
package qdec_pkg;

   typedef enum logic {
      PRIME = 1'b0,
      TRACK = 1'b1
   } qdec_state_e;

   // Forward sequence 00 -> 01 -> 11 -> 10 -> 00
   localparam logic [1:0] FWD_NEXT_00 = 2'b01;
   localparam logic [1:0] FWD_NEXT_01 = 2'b11;
   localparam logic [1:0] FWD_NEXT_11 = 2'b10;
   localparam logic [1:0] FWD_NEXT_10 = 2'b00;

   localparam int DEF_WIDTH       = 8;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_FILT_LEN    = 3;

   function automatic logic [1:0] fwd_next(input logic [1:0] s);
      logic [1:0] n;
      case (s)
         2'b00:   n = FWD_NEXT_00;
         2'b01:   n = FWD_NEXT_01;
         2'b11:   n = FWD_NEXT_11;
         default: n = FWD_NEXT_10;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// ---------------------------------------------------------------------------
// qdec_sync_filter
// One encoder phase: SYNC_STAGES-deep flip-flop synchronizer, followed by an
// optional glitch filter when QDEC_FILTER_EN is defined. The filter output
// only adopts a new level after the synchronized input has held that level
// for FILT_LEN consecutive cycles; shorter pulses are discarded.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth (>= 2)
//   FILT_LEN     stable-cycle count (present only with QDEC_FILTER_EN)
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   din    in   raw phase input, asynchronous to clk
//   dout   out  qualified phase level
// ---------------------------------------------------------------------------
module qdec_sync_filter #(
   parameter int SYNC_STAGES = 2
`ifdef QDEC_FILTER_EN
   ,
   parameter int FILT_LEN    = 3
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [SYNC_STAGES-1:0] sync_p;

   // ---- synchronizer stages ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p <= '0;
      end else begin
         sync_p <= {sync_p[SYNC_STAGES-2:0], din};
      end
   end

`ifdef QDEC_FILTER_EN
   localparam int CNT_W = $clog2(FILT_LEN + 1);

   logic [CNT_W-1:0] cnt;
   logic             filt_p1;

   // ---- filter stage ----
   // cnt counts consecutive cycles the synchronized level differs from the
   // filter output; the FILT_LEN-th such cycle commits the new level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         filt_p1 <= 1'b0;
      end else if (sync_p[SYNC_STAGES-1] == filt_p1) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
         cnt     <= '0;
         filt_p1 <= sync_p[SYNC_STAGES-1];
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign dout = filt_p1;
`else
   assign dout = sync_p[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// ---------------------------------------------------------------------------
// quad_decoder
// Quadrature encoder decoder. A and B are synchronized (and optionally
// filtered) into the qualified state S = {A,B}; S is decoded against the
// previous state P every cycle to step a WIDTH-bit position up or down.
// Optional glitch filter: define QDEC_FILTER_EN.
//
// Parameters:
//   WIDTH        position counter width
//   SYNC_STAGES  synchronizer depth per input (>= 2)
//   FILT_LEN     filter stable-cycle count (used only with QDEC_FILTER_EN)
// Ports:
//   CLK   in   rising-edge clock
//   RST   in   asynchronous active-low reset
//   A, B  in   encoder phases, asynchronous to CLK
//   CLR   in   synchronous clear of POS and ERR (drops a same-cycle step)
//   POS   out  position count (modulo 2^WIDTH)
//   DIR   out  direction of last valid step (1 up, 0 down)
//   STEP  out  one-cycle pulse per valid step
//   WRAP  out  one-cycle pulse when POS wraps either way
//   ERR   out  sticky illegal-transition flag
// ---------------------------------------------------------------------------
module quad_decoder
   import qdec_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FILT_LEN    = DEF_FILT_LEN
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             A,
   input  logic             B,
   input  logic             CLR,
   output logic [WIDTH-1:0] POS,
   output logic             DIR,
   output logic             STEP,
   output logic             WRAP,
   output logic             ERR
);

`ifdef QDEC_FILTER_EN
   localparam int FILT_EN = 1;
`else
   localparam int FILT_EN = 0;
`endif

   // Cycles until S carries real samples. The counter runs to PRIME_LEN
   // inclusive so that the last PRIME edge loads P from a filled pipeline.
   localparam int PRIME_LEN = SYNC_STAGES + FILT_EN * FILT_LEN;
   localparam int PCNT_W    = $clog2(PRIME_LEN + 1);

   logic              a_q;
   logic              b_q;
   logic [1:0]        ab_p0;      // S
   logic [1:0]        ab_p1;      // P
   qdec_state_e       state;
   qdec_state_e       state_nxt;
   logic [PCNT_W-1:0] prime_cnt;
   logic [PCNT_W-1:0] prime_cnt_nxt;
   logic              step_up;
   logic              step_dn;
   logic              illegal;

   function automatic logic [WIDTH-1:0] step_pos(input logic [WIDTH-1:0] pos,
                                                 input logic             up);
      return up ? pos + 1'b1 : pos - 1'b1;
   endfunction

   function automatic logic wrap_hit(input logic [WIDTH-1:0] pos,
                                     input logic             up);
      return up ? (&pos) : ~(|pos);
   endfunction

   // ---- input qualification (sync + optional filter) ----
   qdec_sync_filter #(
      .SYNC_STAGES (SYNC_STAGES)
`ifdef QDEC_FILTER_EN
      ,
      .FILT_LEN    (FILT_LEN)
`endif
   ) u_sync_a (
      .clk   (CLK),
      .rst_n (RST),
      .din   (A),
      .dout  (a_q)
   );

   qdec_sync_filter #(
      .SYNC_STAGES (SYNC_STAGES)
`ifdef QDEC_FILTER_EN
      ,
      .FILT_LEN    (FILT_LEN)
`endif
   ) u_sync_b (
      .clk   (CLK),
      .rst_n (RST),
      .din   (B),
      .dout  (b_q)
   );

   assign ab_p0 = {a_q, b_q};

   // ---- previous-state register and FSM state ----
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ab_p1     <= 2'b00;
         state     <= PRIME;
         prime_cnt <= '0;
      end else begin
         ab_p1     <= ab_p0;
         state     <= state_nxt;
         prime_cnt <= prime_cnt_nxt;
      end
   end

   // ---- next state and decode ----
   always_comb begin
      state_nxt     = state;
      prime_cnt_nxt = prime_cnt;
      step_up       = 1'b0;
      step_dn       = 1'b0;
      illegal       = 1'b0;
      case (state)
         PRIME: begin
            if (prime_cnt == PCNT_W'(PRIME_LEN)) begin
               state_nxt = TRACK;
            end else begin
               prime_cnt_nxt = prime_cnt + 1'b1;
            end
         end
         TRACK: begin
            if (ab_p0 != ab_p1) begin
               if (ab_p0 == fwd_next(ab_p1)) begin
                  step_up = 1'b1;
               end else if (ab_p1 == fwd_next(ab_p0)) begin
                  step_dn = 1'b1;
               end else begin
                  illegal = 1'b1;
               end
            end
         end
         default: state_nxt = PRIME;
      endcase
   end

   // ---- registered outputs ----
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         POS  <= '0;
         DIR  <= 1'b1;
         STEP <= 1'b0;
         WRAP <= 1'b0;
         ERR  <= 1'b0;
      end else begin
         STEP <= 1'b0;
         WRAP <= 1'b0;
         if (CLR) begin
            // A step decoded alongside CLR is dropped entirely; DIR holds.
            POS <= '0;
            ERR <= 1'b0;
         end else begin
            if (step_up || step_dn) begin
               POS  <= step_pos(POS, step_up);
               DIR  <= step_up;
               STEP <= 1'b1;
               WRAP <= wrap_hit(POS, step_up);
            end
            if (illegal) begin
               ERR <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;

   localparam int WIDTH = 8;
   localparam int SS    = 2;
   localparam int FL    = 3;
`ifdef QDEC_FILTER_EN
   localparam int LAT   = SS + FL + 1;
`else
   localparam int LAT   = SS + 1;
`endif

   logic             CLK = 1'b0;
   logic             RST;
   logic             A;
   logic             B;
   logic             CLR;
   logic [WIDTH-1:0] POS;
   logic             DIR;
   logic             STEP;
   logic             WRAP;
   logic             ERR;

   always #5 CLK = ~CLK;

   quad_decoder #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SS),
      .FILT_LEN    (FL)
   ) dut (
      .CLK  (CLK),
      .RST  (RST),
      .A    (A),
      .B    (B),
      .CLR  (CLR),
      .POS  (POS),
      .DIR  (DIR),
      .STEP (STEP),
      .WRAP (WRAP),
      .ERR  (ERR)
   );

   typedef struct packed {
      logic [WIDTH-1:0] pos;
      logic             dir;
      logic             wrap;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks     = 0;
   int   errors     = 0;
   int   steps_seen = 0;
   int   base_steps;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_step(input logic [WIDTH-1:0] pos, input logic dir, input logic wrap);
      exp_t e;
      e.pos  = pos;
      e.dir  = dir;
      e.wrap = wrap;
      sb.push_back(e);
   endtask

   // Monitor: every STEP pulse pops one expected step from the scoreboard.
   always @(negedge CLK) begin
      if (RST === 1'b1) begin
         if (STEP === 1'b1) begin
            steps_seen++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_step: got STEP=1 POS=%0d expected no step", POS);
            end else begin
               mon_e = sb.pop_front();
               chk("step_pos",  32'(POS),  32'(mon_e.pos));
               chk("step_dir",  32'(DIR),  32'(mon_e.dir));
               chk("step_wrap", 32'(WRAP), 32'(mon_e.wrap));
            end
         end else if (WRAP === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wrap_without_step: got WRAP=1 STEP=0 expected WRAP=0");
         end
      end
   end

   task automatic drive(input logic a, input logic b);
      @(negedge CLK);
      A = a;
      B = b;
      repeat (LAT + 3) @(negedge CLK);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   // Step with exact latency check around the POS update edge.
   task automatic drive_timed(input logic a, input logic b,
                              input logic [WIDTH-1:0] old_pos, input logic [WIDTH-1:0] new_pos);
      @(negedge CLK);
      A = a;
      B = b;
      repeat (LAT - 1) @(negedge CLK);
      chk("latency_pos_before", 32'(POS), 32'(old_pos));
      chk("latency_step_before", 32'(STEP), 32'd0);
      @(negedge CLK);
      chk("latency_pos_at", 32'(POS), 32'(new_pos));
      chk("latency_step_at", 32'(STEP), 32'd1);
      repeat (3) @(negedge CLK);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic clr_pulse();
      @(negedge CLK);
      CLR = 1'b1;
      @(negedge CLK);
      CLR = 1'b0;
   endtask

   logic [1:0] fwd_seq [4];

   initial begin
      fwd_seq[0] = 2'b01;
      fwd_seq[1] = 2'b11;
      fwd_seq[2] = 2'b10;
      fwd_seq[3] = 2'b00;

      RST = 1'b0;
      A   = 1'b1;
      B   = 1'b1;
      CLR = 1'b0;
      repeat (3) @(negedge CLK);
      chk("reset_pos",  32'(POS),  32'd0);
      chk("reset_dir",  32'(DIR),  32'd1);
      chk("reset_step", 32'(STEP), 32'd0);
      chk("reset_wrap", 32'(WRAP), 32'd0);
      chk("reset_err",  32'(ERR),  32'd0);

      // Release with A=B=1 held: priming must not see a false transition.
      RST = 1'b1;
      repeat (12) @(negedge CLK);
      chk("prime_err",   32'(ERR),        32'd0);
      chk("prime_pos",   32'(POS),        32'd0);
      chk("prime_steps", 32'(steps_seen), 32'd0);

      // 11 -> 10 -> 00 forward, then clear
      expect_step(8'd1, 1'b1, 1'b0);
      drive_timed(1'b1, 1'b0, 8'd0, 8'd1);
      expect_step(8'd2, 1'b1, 1'b0);
      drive(1'b0, 1'b0);
      clr_pulse();
      chk("clr_pos", 32'(POS), 32'd0);

      // 10 forward transitions from 00
      base_steps = steps_seen;
      for (int i = 0; i < 10; i++) begin
         expect_step(8'(i + 1), 1'b1, 1'b0);
         drive(fwd_seq[i % 4][1], fwd_seq[i % 4][0]);
      end
      chk("fwd10_pos",   32'(POS), 32'd10);
      chk("fwd10_dir",   32'(DIR), 32'd1);
      chk("fwd10_steps", 32'(steps_seen - base_steps), 32'd10);

      // Wrap down then up (state 11)
      clr_pulse();
      chk("clr2_pos", 32'(POS), 32'd0);
      expect_step(8'd255, 1'b0, 1'b1);
      drive(1'b0, 1'b1);
      chk("wrap_dn_pos", 32'(POS), 32'd255);
      chk("wrap_dn_dir", 32'(DIR), 32'd0);
      expect_step(8'd0, 1'b1, 1'b1);
      drive(1'b1, 1'b1);
      chk("wrap_up_pos", 32'(POS), 32'd0);

      // Illegal 11 -> 00
      drive(1'b0, 1'b0);
      chk("illegal_err", 32'(ERR), 32'd1);
      chk("illegal_pos", 32'(POS), 32'd0);
      chk("illegal_dir", 32'(DIR), 32'd1);
      expect_step(8'd1, 1'b1, 1'b0);
      drive(1'b0, 1'b1);
      expect_step(8'd2, 1'b1, 1'b0);
      drive(1'b1, 1'b1);
      chk("err_sticky", 32'(ERR), 32'd1);
      chk("after_illegal_pos", 32'(POS), 32'd2);
      clr_pulse();
      chk("clr_err", 32'(ERR), 32'd0);
      chk("clr3_pos", 32'(POS), 32'd0);

      // CLR coincident with a decoded step (state 11 -> 10 -> 00)
      expect_step(8'd1, 1'b1, 1'b0);
      drive(1'b1, 1'b0);
      @(negedge CLK);
      A = 1'b0;
      B = 1'b0;
      repeat (LAT - 1) @(negedge CLK);
      CLR = 1'b1;
      @(negedge CLK);
      CLR = 1'b0;
      chk("clr_step_pos",  32'(POS),  32'd0);
      chk("clr_step_step", 32'(STEP), 32'd0);
      chk("clr_step_wrap", 32'(WRAP), 32'd0);
      repeat (3) @(negedge CLK);
      chk("clr_step_dir", 32'(DIR), 32'd1);
      // P kept tracking: 00 -> 01 is a clean forward step
      expect_step(8'd1, 1'b1, 1'b0);
      drive(1'b0, 1'b1);
      chk("track_after_clr_err", 32'(ERR), 32'd0);

      // Two-cycle glitch on A from state 01
`ifndef QDEC_FILTER_EN
      expect_step(8'd2, 1'b1, 1'b0);
      expect_step(8'd1, 1'b0, 1'b0);
`endif
      @(negedge CLK);
      A = 1'b1;
      repeat (2) @(negedge CLK);
      A = 1'b0;
      repeat (LAT + 6) @(negedge CLK);
      chk("glitch_pos", 32'(POS), 32'd1);
      chk("glitch_drained", 32'(sb.size()), 32'd0);
      sb.delete();

      // Illegal 01 -> 10, then asynchronous reset mid-operation
      drive(1'b1, 1'b0);
      chk("illegal2_err", 32'(ERR), 32'd1);
      @(negedge CLK);
      #2 RST = 1'b0;
      #1;
      chk("async_rst_pos", 32'(POS), 32'd0);
      chk("async_rst_err", 32'(ERR), 32'd0);
      chk("async_rst_dir", 32'(DIR), 32'd1);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
